// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard control: load-use stall, multi-cycle branch flush, and
// saturating stall/flush event counters for performance debug.
module ifid_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DC_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t          state;
  logic [DC_W-1:0] dcnt;
  logic            hazard;

  // Load in ID/EX writes a register the IF/ID instruction reads (x0 excluded).
  assign hazard = idex_mem_read && (idex_rd != 5'd0) &&
                  ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  // State, flush down-counter and saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      dcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN, LU_STALL: begin
          if (branch_taken) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
            if (FLUSH_CYCLES > 1) begin
              state <= FLUSH;
              dcnt  <= DC_W'(FLUSH_CYCLES - 1);
            end else begin
              state <= RUN;
            end
          end else if ((state == RUN) && hazard) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            state <= LU_STALL;
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          // Further redirects come from squashed instructions and are ignored.
          dcnt <= dcnt - DC_W'(1);
          if (dcnt == DC_W'(1)) state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Mealy control outputs from current state and inputs; forced safe in reset.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN, LU_STALL: begin
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if ((state == RUN) && hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        default: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b0;
          idex_bubble = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Bench for ifid_hazard_ctrl: directed vector table, corner sequences and
// randomized traffic against a behavioural model of two configurations.
module tb_ifid_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       idex_mem_read;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic       branch_taken;

  logic        pcw_a, ifw_a, iff_a, bub_a;
  logic [15:0] sc_a, fc_a;
  logic        pcw_b, ifw_b, iff_b, bub_b;
  logic [1:0]  sc_b, fc_b;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ifid_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .branch_taken(branch_taken), .pc_write(pcw_a), .ifid_write(ifw_a),
    .ifid_flush(iff_a), .idex_bubble(bub_a), .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  ifid_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .branch_taken(branch_taken), .pc_write(pcw_b), .ifid_write(ifw_b),
    .ifid_flush(iff_b), .idex_bubble(bub_b), .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  // Behavioural model: remaining flush cycles, "just stalled" flag, counts.
  int fcyc[2] = '{2, 3};
  int cmax[2] = '{65535, 3};
  int m_rem[2];
  bit m_stl[2];
  int m_sc[2];
  int m_fc[2];

  function automatic bit m_haz();
    return idex_mem_read && (idex_rd != 0) && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, idex_bubble}.
  function automatic int m_out(int i);
    if (!reset_n) return 4'b0011;
    if (m_rem[i] > 0) return 4'b1111;
    if (branch_taken) return 4'b1111;
    if (m_haz() && !m_stl[i]) return 4'b0001;
    return 4'b1100;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_stl[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic m_edge();
    if (!reset_n) begin
      m_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_rem[i] > 0) begin
        m_rem[i]--;
        m_stl[i] = 0;
      end else if (branch_taken) begin
        if (m_fc[i] < cmax[i]) m_fc[i]++;
        m_rem[i] = fcyc[i] - 1;
        m_stl[i] = 0;
      end else if (m_haz() && !m_stl[i]) begin
        if (m_sc[i] < cmax[i]) m_sc[i]++;
        m_stl[i] = 1;
      end else begin
        m_stl[i] = 0;
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act != exp) $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    else n_pass++;
  endtask

  task automatic check_model();
    if (!reset_n) m_reset();
    chk("a_out", int'({pcw_a, ifw_a, iff_a, bub_a}), m_out(0));
    chk("a_stall_cnt", int'(sc_a), m_sc[0]);
    chk("a_flush_cnt", int'(fc_a), m_fc[0]);
    chk("b_out", int'({pcw_b, ifw_b, iff_b, bub_b}), m_out(1));
    chk("b_stall_cnt", int'(sc_b), m_sc[1]);
    chk("b_flush_cnt", int'(fc_b), m_fc[1]);
  endtask

  // One clock: check at negedge, advance model at posedge, return at posedge+1.
  task automatic cycle();
    @(negedge clk);
    check_model();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic drive(bit mr, int rd, int rs1, int rs2, bit br);
    idex_mem_read = mr;
    idex_rd       = 5'(rd);
    ifid_rs1      = 5'(rs1);
    ifid_rs2      = 5'(rs2);
    branch_taken  = br;
  endtask

  typedef struct {
    bit         mr;
    int         rd, rs1, rs2;
    bit         br;
    logic [3:0] exp_o;
    int         exp_sc, exp_fc;
  } vec_t;

  vec_t tab[15];

  initial begin
    // Directed vectors for instance A (FLUSH_CYCLES = 2), starting from reset.
    tab[0]  = '{1'b1, 0, 0, 3, 1'b0, 4'b1100, 0, 0};
    tab[1]  = '{1'b1, 5, 0, 5, 1'b0, 4'b0001, 0, 0};
    tab[2]  = '{1'b1, 5, 0, 5, 1'b0, 4'b1100, 1, 0};
    tab[3]  = '{1'b0, 5, 5, 0, 1'b0, 4'b1100, 1, 0};
    tab[4]  = '{1'b0, 0, 0, 0, 1'b1, 4'b1111, 1, 0};
    tab[5]  = '{1'b0, 0, 0, 0, 1'b0, 4'b1111, 1, 1};
    tab[6]  = '{1'b0, 0, 0, 0, 1'b0, 4'b1100, 1, 1};
    tab[7]  = '{1'b1, 7, 7, 0, 1'b1, 4'b1111, 1, 1};
    tab[8]  = '{1'b1, 7, 7, 0, 1'b1, 4'b1111, 1, 2};
    tab[9]  = '{1'b0, 0, 0, 0, 1'b0, 4'b1100, 1, 2};
    tab[10] = '{1'b1, 9, 9, 1, 1'b0, 4'b0001, 1, 2};
    tab[11] = '{1'b0, 0, 0, 0, 1'b1, 4'b1111, 2, 2};
    tab[12] = '{1'b1, 9, 9, 1, 1'b0, 4'b1111, 2, 3};
    tab[13] = '{1'b1, 9, 9, 1, 1'b0, 4'b0001, 2, 3};
    tab[14] = '{1'b0, 0, 0, 0, 1'b0, 4'b1100, 3, 3};

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", int'({pcw_a, ifw_a, iff_a, bub_a}), 4'b0011);
    chk("reset_cnt", int'(sc_a) + int'(fc_a), 0);
    reset_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      drive(tab[k].mr, tab[k].rd, tab[k].rs1, tab[k].rs2, tab[k].br);
      @(negedge clk);
      chk($sformatf("tab%0d_out", k), int'({pcw_a, ifw_a, iff_a, bub_a}), int'(tab[k].exp_o));
      chk($sformatf("tab%0d_sc", k), int'(sc_a), tab[k].exp_sc);
      chk($sformatf("tab%0d_fc", k), int'(fc_a), tab[k].exp_fc);
      check_model();
      @(posedge clk);
      m_edge();
      #1;
    end

    // Asynchronous reset during the first FLUSH cycle.
    drive(0, 0, 0, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out", int'({pcw_a, ifw_a, iff_a, bub_a}), 4'b0011);
    chk("async_rst_sc", int'(sc_a), 0);
    chk("async_rst_fc", int'(fc_a), 0);
    m_reset();
    @(posedge clk);
    m_edge();
    #1;
    reset_n = 1'b1;
    cycle();
    chk("post_rst_out", int'({pcw_a, ifw_a, iff_a, bub_a}), 4'b1100);

    // Five stalls: 2-bit counter saturates at 3, 16-bit reaches 5.
    for (int k = 0; k < 5; k++) begin
      drive(1, 4, 4, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0);
      cycle();
    end
    chk("sat_b_stall", int'(sc_b), 3);
    chk("sat_a_stall", int'(sc_a), 5);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 2000; k++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0));
      reset_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
